rv32i_mc_control_unit: RTL and testbench

Parametrised multi-cycle control unit for the RV32I core. It sequences IDLE→FETCH→DECODE→EXECUTE→MEM→WRITEBACK and adds three things to the base state set:
- a variable-latency memory handshake (mem_req/mem_ready) with an optional timeout;
- a TRAP state for illegal opcodes, ECALL, EBREAK and bus timeouts;
- a retired-instruction counter.

It drives datapath strobes only. PC arithmetic, ALU and register file live in the datapath.

---
 rtl/rv32i_mc_control_unit_pkg.sv | 59 +++++
 rtl/rv32i_mc_control_unit_if.sv | 10 +
 rtl/rv32i_mem_wait_timer.sv | 38 +++
 rtl/rv32i_mc_control_unit.sv | 155 +++++++++++++++
 tb/tb_rv32i_mc_control_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_mc_control_unit_pkg.sv
// Shared types for the RV32I multi-cycle control unit: FSM states, trap causes,
// datapath mux selects and the set of opcodes DECODE accepts.
package rv32i_mc_control_unit_pkg;

  typedef enum logic [2:0] {
    IDLE_S0      = 3'd0,
    FETCH_S1     = 3'd1,
    DECODE_S2    = 3'd2,
    EXECUTE_S3   = 3'd3,
    MEM_S4       = 3'd4,
    WRITEBACK_S5 = 3'd5,
    TRAP_S6      = 3'd6
  } rv32i_state_t;

  typedef enum logic [1:0] {
    CAUSE_ILLEGAL     = 2'd0,
    CAUSE_ECALL       = 2'd1,
    CAUSE_EBREAK      = 2'd2,
    CAUSE_BUS_TIMEOUT = 2'd3
  } RV32I_TRAP_CAUSE_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2,
    RES_IMM = 2'd3
  } RV32I_RESULT_SRC_t;

  typedef enum logic {
    PC_PLUS4  = 1'b0,
    PC_TARGET = 1'b1
  } RV32I_PC_SRC_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ENV   = 7'b1110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_J     = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam int NUM_LEGAL_OPS = 10;
  localparam logic [6:0] LEGAL_OPCODES [NUM_LEGAL_OPS] = '{
    OP_R, OP_I, OP_LOAD, OP_JALR, OP_ENV, OP_S, OP_B, OP_J, OP_LUI, OP_AUIPC
  };

  function automatic logic is_legal_opcode(input logic [6:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_LEGAL_OPS; i++) begin
      if (op == LEGAL_OPCODES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/rv32i_mc_control_unit_if.sv
// Memory request bus between the control unit (master) and the memory (slave).
interface rv32i_mc_control_unit_if;
  logic mem_req;
  logic mem_we;
  logic mem_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_sel, output mem_ready);
endinterface

// File: rtl/rv32i_mem_wait_timer.sv
// Counts cycles an active memory request goes unanswered; flags a timeout on the
// cycle the count would reach MEM_WAIT_MAX (never when MEM_WAIT_MAX is 0).
module rv32i_mem_wait_timer #(
  parameter int MEM_WAIT_MAX   = 16,
  parameter int WAIT_CNT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  input  logic clear,
  output logic timeout
);

  localparam logic [WAIT_CNT_WIDTH-1:0] LIMIT =
    (MEM_WAIT_MAX == 0) ? '0 : WAIT_CNT_WIDTH'(MEM_WAIT_MAX - 1);
  localparam logic [WAIT_CNT_WIDTH-1:0] SAT = '1;

  logic [WAIT_CNT_WIDTH-1:0] cnt_q, cnt_d;

  // A ready on the limit cycle wins, so timeout is gated by !ready.
  assign timeout = (MEM_WAIT_MAX != 0) && active && !ready && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (active && !ready && (cnt_q != SAT)) begin
      cnt_d = cnt_q + WAIT_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rv32i_mc_control_unit.sv
// Multi-cycle RV32I control FSM with variable-latency memory handshake, trap
// state and retired-instruction counter. Drives datapath strobes only.
module rv32i_mc_control_unit
  import rv32i_mc_control_unit_pkg::*;
#(
  parameter int MEM_WAIT_MAX     = 16,
  parameter int RETIRE_CNT_WIDTH = 32,
  parameter int WAIT_CNT_WIDTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [6:0]                  opcode,
  input  logic                        instr_bit20,
  input  logic                        branch_taken,
  input  logic                        trap_ack,
  rv32i_mc_control_unit_if.master     mem,
  output rv32i_state_t                state,
  output logic                        ir_write,
  output logic                        pc_write,
  output logic                        pc_src,
  output logic                        reg_write,
  output logic [1:0]                  result_src,
  output logic                        trap_valid,
  output logic [1:0]                  trap_cause,
  output logic [RETIRE_CNT_WIDTH-1:0] retired_cnt
);

  rv32i_state_t                state_q, state_d;
  RV32I_TRAP_CAUSE_t           cause_q, cause_d;
  logic [RETIRE_CNT_WIDTH-1:0] retired_q, retired_d;
  RV32I_RESULT_SRC_t           result_src_c;
  logic mem_req_c, mem_we_c, mem_sel_c, retire_c, timeout;

  rv32i_mem_wait_timer #(
    .MEM_WAIT_MAX  (MEM_WAIT_MAX),
    .WAIT_CNT_WIDTH(WAIT_CNT_WIDTH)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .active (mem_req_c),
    .ready  (mem.mem_ready),
    .clear  (state_d != state_q),
    .timeout(timeout)
  );

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    reg_write    = 1'b0;
    result_src_c = RES_ALU;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    mem_sel_c    = 1'b0;
    trap_valid   = 1'b0;
    retire_c     = 1'b0;
    case (state_q)
      IDLE_S0: if (start) state_d = FETCH_S1;
      FETCH_S1: begin
        mem_req_c = 1'b1;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          state_d  = DECODE_S2;
        end else if (timeout) begin
          cause_d = CAUSE_BUS_TIMEOUT;
          state_d = TRAP_S6;
        end
      end
      DECODE_S2: begin
        if (is_legal_opcode(opcode)) begin
          state_d = EXECUTE_S3;
        end else begin
          cause_d = CAUSE_ILLEGAL;
          state_d = TRAP_S6;
        end
      end
      EXECUTE_S3: begin
        case (opcode)
          OP_LOAD, OP_S: state_d = MEM_S4;
          OP_B: begin
            pc_write = 1'b1;
            pc_src   = branch_taken;
            retire_c = 1'b1;
            state_d  = FETCH_S1;
          end
          OP_ENV: begin
            cause_d = instr_bit20 ? CAUSE_EBREAK : CAUSE_ECALL;
            state_d = TRAP_S6;
          end
          default: state_d = WRITEBACK_S5;
        endcase
      end
      MEM_S4: begin
        mem_req_c = 1'b1;
        mem_sel_c = 1'b1;
        mem_we_c  = (opcode == OP_S);
        if (mem.mem_ready) begin
          if (opcode == OP_S) begin
            pc_write = 1'b1;
            retire_c = 1'b1;
            state_d  = FETCH_S1;
          end else begin
            state_d = WRITEBACK_S5;
          end
        end else if (timeout) begin
          cause_d = CAUSE_BUS_TIMEOUT;
          state_d = TRAP_S6;
        end
      end
      WRITEBACK_S5: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire_c  = 1'b1;
        pc_src    = (opcode == OP_J) || (opcode == OP_JALR);
        case (opcode)
          OP_LOAD:       result_src_c = RES_MEM;
          OP_J, OP_JALR: result_src_c = RES_PC4;
          OP_LUI:        result_src_c = RES_IMM;
          default:       result_src_c = RES_ALU;
        endcase
        state_d = FETCH_S1;
      end
      TRAP_S6: begin
        trap_valid = 1'b1;
        if (trap_ack) state_d = IDLE_S0;
      end
      default: state_d = IDLE_S0;
    endcase
    retired_d = retired_q + (retire_c ? RETIRE_CNT_WIDTH'(1) : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE_S0;
      cause_q   <= CAUSE_ILLEGAL;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  assign state       = state_q;
  assign result_src  = result_src_c;
  assign trap_cause  = cause_q;
  assign retired_cnt = retired_q;
  assign mem.mem_req = mem_req_c;
  assign mem.mem_we  = mem_we_c;
  assign mem.mem_sel = mem_sel_c;

endmodule

// File: tb/tb_rv32i_mc_control_unit.sv
// Cycle-by-cycle vector bench for rv32i_mc_control_unit (MEM_WAIT_MAX=4, 4-bit retire counter).
module tb_rv32i_mc_control_unit;
  import rv32i_mc_control_unit_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [6:0]   opcode = 7'd0;
  logic         instr_bit20 = 1'b0;
  logic         branch_taken = 1'b0;
  logic         trap_ack = 1'b0;
  rv32i_state_t state;
  logic         ir_write, pc_write, pc_src, reg_write, trap_valid;
  logic [1:0]   result_src, trap_cause;
  logic [3:0]   retired_cnt;

  rv32i_mc_control_unit_if bus();

  always #5 clk = ~clk;

  rv32i_mc_control_unit #(
    .MEM_WAIT_MAX    (4),
    .RETIRE_CNT_WIDTH(4),
    .WAIT_CNT_WIDTH  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .opcode      (opcode),
    .instr_bit20 (instr_bit20),
    .branch_taken(branch_taken),
    .trap_ack    (trap_ack),
    .mem         (bus),
    .state       (state),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .trap_valid  (trap_valid),
    .trap_cause  (trap_cause),
    .retired_cnt (retired_cnt)
  );

  // Strobe field order: ir pw ps rw | rs[1:0] | mr mw ms | tv
  localparam logic [9:0] S_NONE  = 10'b0000_00_000_0;
  localparam logic [9:0] S_FETCH = 10'b1000_00_100_0;
  localparam logic [9:0] S_FWAIT = 10'b0000_00_100_0;
  localparam logic [9:0] S_MRD   = 10'b0000_00_101_0;
  localparam logic [9:0] S_MWR   = 10'b0000_00_111_0;
  localparam logic [9:0] S_MWDN  = 10'b0100_00_111_0;
  localparam logic [9:0] S_BRT   = 10'b0110_00_000_0;
  localparam logic [9:0] S_BRN   = 10'b0100_00_000_0;
  localparam logic [9:0] S_WALU  = 10'b0101_00_000_0;
  localparam logic [9:0] S_WMEM  = 10'b0101_01_000_0;
  localparam logic [9:0] S_WPC4  = 10'b0111_10_000_0;
  localparam logic [9:0] S_WIMM  = 10'b0101_11_000_0;
  localparam logic [9:0] S_TRAP  = 10'b0000_00_000_1;

  localparam logic [2:0] IDL = 3'(IDLE_S0);
  localparam logic [2:0] FET = 3'(FETCH_S1);
  localparam logic [2:0] DEC = 3'(DECODE_S2);
  localparam logic [2:0] EXE = 3'(EXECUTE_S3);
  localparam logic [2:0] MEM = 3'(MEM_S4);
  localparam logic [2:0] WBK = 3'(WRITEBACK_S5);
  localparam logic [2:0] TRP = 3'(TRAP_S6);

  typedef struct {
    string       tag;
    logic        rst, start;
    logic [6:0]  op;
    logic        b20, bt, rdy, ack;
    logic [18:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [18:0] exp_q[$];
  string       tag_q[$];
  int          total = 0;
  int          bad = 0;

  function automatic void add(input string tag, input logic r, input logic s,
                              input logic [6:0] op, input logic b20, input logic bt,
                              input logic rdy, input logic ack, input logic [2:0] st,
                              input logic [9:0] stb, input logic [1:0] tc,
                              input logic [3:0] rc);
    vec_t v;
    v.tag = tag; v.rst = r; v.start = s; v.op = op;
    v.b20 = b20; v.bt = bt; v.rdy = rdy; v.ack = ack;
    v.exp = {st, stb, tc, rc};
    tbl.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    logic [18:0] act, e;
    string       t;
    @(posedge clk);
    #1;
    rst = v.rst; start = v.start; opcode = v.op; instr_bit20 = v.b20;
    branch_taken = v.bt; bus.mem_ready = v.rdy; trap_ack = v.ack;
    exp_q.push_back(v.exp);
    tag_q.push_back(v.tag);
    @(negedge clk);
    act = {state, ir_write, pc_write, pc_src, reg_write, result_src,
           bus.mem_req, bus.mem_we, bus.mem_sel, trap_valid, trap_cause, retired_cnt};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got st=%0d stb=%b tc=%0d rc=%0d, need st=%0d stb=%b tc=%0d rc=%0d",
               t, act[18:16], act[15:6], act[5:4], act[3:0],
               e[18:16], e[15:6], e[5:4], e[3:0]);
    end
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    //   tag         rst st op     b20 bt rdy ack  state stb     tc  rc
    add("reset",     0, 0, 7'h00, 0, 0, 0, 0,   IDL, S_NONE,  0,  0);
    add("idle",      0, 1, 7'h00, 0, 0, 0, 0,   IDL, S_NONE,  0,  0);
    add("add_fet",   0, 0, OP_R,  0, 0, 1, 0,   FET, S_FETCH, 0,  0);
    add("add_dec",   0, 1, OP_R,  0, 0, 0, 0,   DEC, S_NONE,  0,  0);
    add("add_exe",   0, 0, OP_R,  0, 0, 0, 0,   EXE, S_NONE,  0,  0);
    add("add_wb",    0, 0, OP_R,  0, 0, 0, 0,   WBK, S_WALU,  0,  0);
    add("lw_fet",    0, 0, OP_LOAD,0,0, 1, 0,   FET, S_FETCH, 0,  1);
    add("lw_dec",    0, 0, OP_LOAD,0,0, 0, 0,   DEC, S_NONE,  0,  1);
    add("lw_exe",    0, 0, OP_LOAD,0,0, 0, 0,   EXE, S_NONE,  0,  1);
    add("lw_mem0",   0, 0, OP_LOAD,0,0, 0, 0,   MEM, S_MRD,   0,  1);
    add("lw_mem1",   0, 0, OP_LOAD,0,0, 0, 0,   MEM, S_MRD,   0,  1);
    add("lw_mem2",   0, 0, OP_LOAD,0,0, 0, 0,   MEM, S_MRD,   0,  1);
    add("lw_memlim", 0, 0, OP_LOAD,0,0, 1, 0,   MEM, S_MRD,   0,  1);
    add("lw_wb",     0, 0, OP_LOAD,0,0, 0, 0,   WBK, S_WMEM,  0,  1);
    add("sw_fet",    0, 0, OP_S,  0, 0, 1, 0,   FET, S_FETCH, 0,  2);
    add("sw_dec",    0, 0, OP_S,  0, 0, 0, 0,   DEC, S_NONE,  0,  2);
    add("sw_exe",    0, 0, OP_S,  0, 0, 0, 0,   EXE, S_NONE,  0,  2);
    add("sw_mem",    0, 0, OP_S,  0, 0, 1, 0,   MEM, S_MWDN,  0,  2);
    add("bt_fet",    0, 0, OP_B,  0, 1, 1, 0,   FET, S_FETCH, 0,  3);
    add("bt_dec",    0, 0, OP_B,  0, 1, 0, 0,   DEC, S_NONE,  0,  3);
    add("bt_exe",    0, 0, OP_B,  0, 1, 0, 0,   EXE, S_BRT,   0,  3);
    add("bn_fet",    0, 0, OP_B,  0, 0, 1, 0,   FET, S_FETCH, 0,  4);
    add("bn_dec",    0, 0, OP_B,  0, 0, 0, 0,   DEC, S_NONE,  0,  4);
    add("bn_exe",    0, 0, OP_B,  0, 0, 0, 0,   EXE, S_BRN,   0,  4);
    add("jal_fet",   0, 0, OP_J,  0, 0, 1, 0,   FET, S_FETCH, 0,  5);
    add("jal_dec",   0, 0, OP_J,  0, 0, 0, 0,   DEC, S_NONE,  0,  5);
    add("jal_exe",   0, 0, OP_J,  0, 0, 0, 0,   EXE, S_NONE,  0,  5);
    add("jal_wb",    0, 0, OP_J,  0, 0, 0, 0,   WBK, S_WPC4,  0,  5);
    add("lui_fet",   0, 0, OP_LUI,0, 0, 1, 0,   FET, S_FETCH, 0,  6);
    add("lui_dec",   0, 0, OP_LUI,0, 0, 0, 0,   DEC, S_NONE,  0,  6);
    add("lui_exe",   0, 0, OP_LUI,0, 0, 0, 0,   EXE, S_NONE,  0,  6);
    add("lui_wb",    0, 0, OP_LUI,0, 0, 0, 0,   WBK, S_WIMM,  0,  6);
    add("aui_fet",   0, 0, OP_AUIPC,0,0,1, 0,   FET, S_FETCH, 0,  7);
    add("aui_dec",   0, 0, OP_AUIPC,0,0,0, 0,   DEC, S_NONE,  0,  7);
    add("aui_exe",   0, 0, OP_AUIPC,0,0,0, 0,   EXE, S_NONE,  0,  7);
    add("aui_wb",    0, 0, OP_AUIPC,0,0,0, 0,   WBK, S_WALU,  0,  7);
    add("jalr_fet",  0, 0, OP_JALR,0,0, 1, 0,   FET, S_FETCH, 0,  8);
    add("jalr_dec",  0, 0, OP_JALR,0,0, 0, 0,   DEC, S_NONE,  0,  8);
    add("jalr_exe",  0, 0, OP_JALR,0,0, 0, 0,   EXE, S_NONE,  0,  8);
    add("jalr_wb",   0, 0, OP_JALR,0,0, 0, 0,   WBK, S_WPC4,  0,  8);
    add("ill_fet",   0, 0, 7'h7F, 0, 0, 1, 0,   FET, S_FETCH, 0,  9);
    add("ill_dec",   0, 0, 7'h7F, 0, 0, 0, 0,   DEC, S_NONE,  0,  9);
    add("ill_trap",  0, 0, 7'h7F, 0, 0, 0, 0,   TRP, S_TRAP,  0,  9);
    add("ill_ack",   0, 0, 7'h7F, 0, 0, 0, 1,   TRP, S_TRAP,  0,  9);
    add("ill_idle",  0, 1, 7'h7F, 0, 0, 0, 0,   IDL, S_NONE,  0,  9);
    add("ebk_fet",   0, 0, OP_ENV,1, 0, 1, 0,   FET, S_FETCH, 0,  9);
    add("ebk_dec",   0, 0, OP_ENV,1, 0, 0, 0,   DEC, S_NONE,  0,  9);
    add("ebk_exe",   0, 0, OP_ENV,1, 0, 0, 0,   EXE, S_NONE,  0,  9);
    add("ebk_trap",  0, 1, OP_ENV,1, 0, 0, 1,   TRP, S_TRAP,  2,  9);
    add("ebk_idle",  0, 1, OP_ENV,0, 0, 0, 0,   IDL, S_NONE,  2,  9);
    add("ecl_fet",   0, 0, OP_ENV,0, 0, 1, 0,   FET, S_FETCH, 2,  9);
    add("ecl_dec",   0, 0, OP_ENV,0, 0, 0, 0,   DEC, S_NONE,  2,  9);
    add("ecl_exe",   0, 0, OP_ENV,0, 0, 0, 0,   EXE, S_NONE,  2,  9);
    add("ecl_trap",  0, 0, OP_ENV,0, 0, 0, 1,   TRP, S_TRAP,  1,  9);
    add("ecl_idle",  0, 1, OP_ENV,0, 0, 0, 0,   IDL, S_NONE,  1,  9);
    add("to_w0",     0, 0, OP_R,  0, 0, 0, 0,   FET, S_FWAIT, 1,  9);
    add("to_w1",     0, 0, OP_R,  0, 0, 0, 0,   FET, S_FWAIT, 1,  9);
    add("to_w2",     0, 0, OP_R,  0, 0, 0, 0,   FET, S_FWAIT, 1,  9);
    add("to_w3",     0, 0, OP_R,  0, 0, 0, 1,   FET, S_FWAIT, 1,  9);
    add("to_trap",   0, 0, OP_R,  0, 0, 0, 0,   TRP, S_TRAP,  3,  9);
    add("to_ack",    0, 0, OP_R,  0, 0, 0, 1,   TRP, S_TRAP,  3,  9);
    add("to_idle",   0, 1, OP_R,  0, 0, 0, 0,   IDL, S_NONE,  3,  9);
    // Reset in the middle of a stalled store.
    add("rs_fet",    0, 0, OP_S,  0, 0, 1, 0,   FET, S_FETCH, 3,  9);
    add("rs_dec",    0, 0, OP_S,  0, 0, 0, 0,   DEC, S_NONE,  3,  9);
    add("rs_exe",    0, 0, OP_S,  0, 0, 0, 0,   EXE, S_NONE,  3,  9);
    add("rs_mem0",   0, 0, OP_S,  0, 0, 0, 0,   MEM, S_MWR,   3,  9);
    add("rs_mem1",   1, 0, OP_S,  0, 0, 0, 0,   MEM, S_MWR,   3,  9);
    add("rs_idle",   0, 0, OP_S,  0, 0, 0, 0,   IDL, S_NONE,  0,  0);
    add("rs_start",  0, 1, OP_B,  0, 0, 0, 0,   IDL, S_NONE,  0,  0);
    // Sixteen back-to-back branches wrap the 4-bit retire counter.
    for (int k = 0; k < 16; k++) begin
      add("wr_fet",  0, 0, OP_B,  0, 0, 1, 0,   FET, S_FETCH, 0,  4'(k));
      add("wr_dec",  0, 0, OP_B,  0, 0, 0, 0,   DEC, S_NONE,  0,  4'(k));
      add("wr_exe",  0, 0, OP_B,  0, 0, 0, 0,   EXE, S_BRN,   0,  4'(k));
    end
    add("wrap",      0, 0, OP_B,  0, 0, 0, 0,   FET, S_FWAIT, 0,  0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
